scan_chain_ctrl: RTL and testbench

Sequencer for one chain of scan flip-flops (mux-scan cells with SE/SI/D and active-low set). It shifts a parallel test pattern into the chain serially, drops scan-enable for a capture pulse, then unloads the captured response serially and compares it bit-by-bit against an expected vector. It sits between the on-chip test engine and the chain's SE/SI/SO/SETN pins.

---
 rtl/scan_chain_ctrl_if.sv | 48 ++++
 rtl/scan_chain_ctrl.sv | 147 ++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
// ----------------------------------------------------------------------------
// scan_chain_ctrl_if
// Bundles the test-engine request/response signals and the chain pins
// for one scan_chain_ctrl instance.
//   START      : one-cycle run request from the test engine
//   PAT / EXP  : load pattern / expected response (CHAIN_LEN bits)
//   SO         : serial output of the chain's last cell
//   SE / SI    : scan enable / serial input to the chain
//   CHAIN_SETN : active-low preset to the chain cells
//   BUSY/DONE  : run status; DONE pulses for one cycle at the end of unload
//   FAIL/RESP  : sticky mismatch flag / unloaded response
//   SIG        : 16-bit MISR signature (only with SCAN_CTRL_MISR_EN)
// Modports: slave = the controller, master = the test engine / chain side.
// ----------------------------------------------------------------------------
interface scan_chain_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8
);
  logic                 START;
  logic [CHAIN_LEN-1:0] PAT;
  logic [CHAIN_LEN-1:0] EXP;
  logic                 SO;
  logic                 SE;
  logic                 SI;
  logic                 CHAIN_SETN;
  logic                 BUSY;
  logic                 DONE;
  logic                 FAIL;
  logic [CHAIN_LEN-1:0] RESP;
`ifdef SCAN_CTRL_MISR_EN
  logic [15:0]          SIG;
`endif

  modport slave (
    input  START, PAT, EXP, SO,
`ifdef SCAN_CTRL_MISR_EN
    output SIG,
`endif
    output SE, SI, CHAIN_SETN, BUSY, DONE, FAIL, RESP
  );

  modport master (
    output START, PAT, EXP, SO,
`ifdef SCAN_CTRL_MISR_EN
    input  SIG,
`endif
    input  SE, SI, CHAIN_SETN, BUSY, DONE, FAIL, RESP
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// ----------------------------------------------------------------------------
// scan_chain_ctrl
// Sequencer for one mux-scan chain: presets the chain, shifts PAT in
// serially (bit 0 first), drops SE for CAP_CYCLES capture cycles, then
// unloads the response serially while comparing it with EXP.
// Ports:
//   CLK : rising-edge clock, shared with the chain
//   RN  : synchronous active-low reset
//   bus : scan_chain_ctrl_if.slave (START/PAT/EXP/SO in,
//         SE/SI/CHAIN_SETN/BUSY/DONE/FAIL/RESP[/SIG] out)
// Parameters: CHAIN_LEN (2..256), CAP_CYCLES (1..4).
// Optional macro SCAN_CTRL_MISR_EN adds a 16-bit MISR signature on bus.SIG
// (x^16+x^12+x^5+1, seed 16'hFFFF).
// All outputs are registers or decodes of the state register.
// ----------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN  = 8,
  parameter int unsigned CAP_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RN,
  scan_chain_ctrl_if.slave     bus
);

  localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [1:0]       CAP_LAST = 2'(CAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PRESET  = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_UNLOAD  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_cap_cnt;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_exp;
  logic [CHAIN_LEN-1:0] r_resp;
  logic                 r_fail;
  // Low through reset, high from the first cycle after release; keeps
  // CHAIN_SETN registered instead of following RN combinationally.
  logic                 r_setn_ok;

`ifdef SCAN_CTRL_MISR_EN
  logic [15:0] r_sig;
  logic [15:0] w_sig_in;
  logic [15:0] w_sig_next;

  // SO folds into bit 0 first, then a left shift with feedback from bit 15.
  always_comb begin
    w_sig_in   = {r_sig[15:1], r_sig[0] ^ bus.SO};
    w_sig_next = {w_sig_in[14:0], 1'b0} ^ ({16{w_sig_in[15]}} & 16'h1021);
  end

  assign bus.SIG = r_sig;
`else
  // No signature register in this build.
`endif

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cap_cnt <= '0;
      r_pat     <= '0;
      r_exp     <= '0;
      r_resp    <= '0;
      r_fail    <= 1'b0;
      r_setn_ok <= 1'b0;
`ifdef SCAN_CTRL_MISR_EN
      r_sig     <= 16'hFFFF;
`endif
    end else begin
      r_setn_ok <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.START) begin
            r_pat   <= bus.PAT;
            r_exp   <= bus.EXP;
            r_fail  <= 1'b0;
            r_resp  <= '0;
            r_cnt   <= '0;
            r_state <= S_PRESET;
`ifdef SCAN_CTRL_MISR_EN
            r_sig   <= 16'hFFFF;
`endif
          end
        end
        S_PRESET: begin
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_cap_cnt <= '0;
            r_state   <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          if (r_cap_cnt == CAP_LAST) begin
            r_cnt     <= '0;
            r_cap_cnt <= '0;
            r_state   <= S_UNLOAD;
          end else begin
            r_cap_cnt <= r_cap_cnt + 2'd1;
          end
        end
        S_UNLOAD: begin
          r_resp[r_cnt] <= bus.SO;
          if (bus.SO != r_exp[r_cnt]) begin
            r_fail <= 1'b1;
          end
`ifdef SCAN_CTRL_MISR_EN
          r_sig <= w_sig_next;
`endif
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.SE         = (r_state == S_SHIFT) || (r_state == S_UNLOAD);
  assign bus.SI         = (r_state == S_SHIFT) && r_pat[r_cnt];
  assign bus.CHAIN_SETN = r_setn_ok && (r_state != S_PRESET);
  assign bus.BUSY       = (r_state != S_IDLE);
  assign bus.DONE       = (r_state == S_DONE);
  assign bus.FAIL       = r_fail;
  assign bus.RESP       = r_resp;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
module tb_scan_chain_ctrl;

  logic CLK = 1'b0;
  logic RN  = 1'b0;
  always #5 CLK = ~CLK;

  // DUT A: CAP_CYCLES=1, chain A; DUT B: CAP_CYCLES=3, chain B (always inverting)
  scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifa ();
  scan_chain_ctrl_if #(.CHAIN_LEN(8)) ifb ();

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(1)) u_dut_a (
    .CLK(CLK), .RN(RN), .bus(ifa.slave));
  scan_chain_ctrl #(.CHAIN_LEN(8), .CAP_CYCLES(3)) u_dut_b (
    .CLK(CLK), .RN(RN), .bus(ifb.slave));

  // Behavioural chains: cell 0 takes SI, cell 7 drives SO.
  logic [7:0] ch_a, ch_b;
  bit         cap_inv;
  always @(posedge CLK) begin
    if (!ifa.CHAIN_SETN)   ch_a <= '1;
    else if (ifa.SE)       ch_a <= {ch_a[6:0], ifa.SI};
    else if (cap_inv)      ch_a <= ~ch_a;
  end
  always @(posedge CLK) begin
    if (!ifb.CHAIN_SETN)   ch_b <= '1;
    else if (ifb.SE)       ch_b <= {ch_b[6:0], ifb.SI};
    else                   ch_b <= ~ch_b;
  end
  assign ifa.SO = ch_a[7];
  assign ifb.SO = ch_b[7];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] misr_ref(input logic [7:0] r);
    logic [15:0] s;
    logic        fb;
    s = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      s[0] = s[0] ^ r[i];
      fb   = s[15];
      s    = s << 1;
      if (fb) s = s ^ 16'b0001_0000_0010_0001;
    end
    return s;
  endfunction

  typedef struct {
    logic [7:0] pat;
    logic [7:0] expv;
    bit         inv;
    logic [7:0] resp;
    int         fail_cyc;   // first cycle FAIL reads 1; 0 = never
  } vec_t;

  vec_t vecs[8];

  // Runs one pattern on DUT A starting in the current (idle) cycle.
  task automatic run_a(input vec_t v, input int idx);
    int cyc, se_hi, setn_lo, first_se, fail_first;
    logic [7:0] si_bits;
    string tag;
    tag = $sformatf("v%0d", idx);
    cap_inv = v.inv;
    ifa.PAT = v.pat;
    ifa.EXP = v.expv;
    ifa.START = 1'b1;
    tick();
    ifa.START = 1'b0;
    chk({tag, "_clr_fail"}, 32'(ifa.FAIL), 32'd0);
    chk({tag, "_clr_resp"}, 32'(ifa.RESP), 32'd0);
    cyc = 1; se_hi = 0; setn_lo = 0; first_se = 0; fail_first = 0; si_bits = '0;
    forever begin
      if (ifa.SE) begin
        se_hi++;
        if (first_se == 0) first_se = cyc;
      end
      if (cyc >= 2 && cyc <= 9) si_bits[cyc-2] = ifa.SI;
      if (!ifa.CHAIN_SETN) setn_lo++;
      if (ifa.FAIL && fail_first == 0) fail_first = cyc;
      if (ifa.DONE || cyc >= 100) break;
      tick();
      cyc++;
    end
    chk({tag, "_done_cyc"}, 32'(cyc), 32'd19);
    chk({tag, "_si_bits"}, 32'(si_bits), 32'(v.pat));
    chk({tag, "_se_hi"}, 32'(se_hi), 32'd16);
    chk({tag, "_first_se"}, 32'(first_se), 32'd2);
    chk({tag, "_setn_lo"}, 32'(setn_lo), 32'd1);
    chk({tag, "_resp"}, 32'(ifa.RESP), 32'(v.resp));
    chk({tag, "_fail_cyc"}, 32'(fail_first), 32'(v.fail_cyc));
`ifdef SCAN_CTRL_MISR_EN
    chk({tag, "_sig"}, 32'(ifa.SIG), 32'(misr_ref(v.resp)));
`endif
    tick();
    chk({tag, "_idle_done"}, 32'(ifa.DONE), 32'd0);
    chk({tag, "_idle_busy"}, 32'(ifa.BUSY), 32'd0);
    chk({tag, "_hold_resp"}, 32'(ifa.RESP), 32'(v.resp));
    chk({tag, "_hold_fail"}, 32'(ifa.FAIL), 32'(v.fail_cyc != 0));
  endtask

  initial begin
    int cyc, se_hi, done_cnt, si_toggles;
    logic last_si;

    vecs[0] = '{8'hA5, 8'h5A, 1'b1, 8'h5A, 0};
    vecs[1] = '{8'hA5, 8'h5B, 1'b1, 8'h5A, 12};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 0};
    vecs[3] = '{8'h3C, 8'hC3, 1'b1, 8'hC3, 0};
    vecs[4] = '{8'hFF, 8'hFF, 1'b0, 8'hFF, 0};
    vecs[5] = '{8'h01, 8'h00, 1'b0, 8'h01, 12};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h80, 0};
    vecs[7] = '{8'h80, 8'h00, 1'b0, 8'h80, 19};

    cap_inv = 1'b0;
    ifa.START = 1'b0; ifa.PAT = '0; ifa.EXP = '0;
    ifb.START = 1'b0; ifb.PAT = '0; ifb.EXP = '0;

    // Power-on reset
    RN = 1'b0;
    tick(); tick();
    chk("rst_se",   32'(ifa.SE), 32'd0);
    chk("rst_si",   32'(ifa.SI), 32'd0);
    chk("rst_busy", 32'(ifa.BUSY), 32'd0);
    chk("rst_done", 32'(ifa.DONE), 32'd0);
    chk("rst_fail", 32'(ifa.FAIL), 32'd0);
    chk("rst_resp", 32'(ifa.RESP), 32'd0);
    chk("rst_setn", 32'(ifa.CHAIN_SETN), 32'd0);
`ifdef SCAN_CTRL_MISR_EN
    chk("rst_sig",  32'(ifa.SIG), 32'hFFFF);
`endif
    RN = 1'b1;
    tick();
    chk("rel_setn", 32'(ifa.CHAIN_SETN), 32'd1);
    chk("rel_busy", 32'(ifa.BUSY), 32'd0);

    // Back-to-back runs: each START lands in the first idle cycle after DONE
    for (int i = 0; i < 8; i++) run_a(vecs[i], i);

    // Reset mid-SHIFT (FAIL is set from the last vector)
    ifa.PAT = 8'hA5; ifa.EXP = 8'h5A; cap_inv = 1'b1;
    ifa.START = 1'b1;
    tick();
    ifa.START = 1'b0;
    tick(); tick(); tick();          // now in cycle 4
    chk("mid_shift_se", 32'(ifa.SE), 32'd1);
    RN = 1'b0;
    tick();
    chk("mrst_se",   32'(ifa.SE), 32'd0);
    chk("mrst_busy", 32'(ifa.BUSY), 32'd0);
    chk("mrst_setn", 32'(ifa.CHAIN_SETN), 32'd0);
    chk("mrst_fail", 32'(ifa.FAIL), 32'd0);
    chk("mrst_resp", 32'(ifa.RESP), 32'd0);
    si_toggles = 0; last_si = ifa.SI;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifa.SI !== last_si) si_toggles++;
      last_si = ifa.SI;
    end
    chk("mrst_si_toggles", 32'(si_toggles), 32'd0);
    chk("mrst_si", 32'(ifa.SI), 32'd0);
    RN = 1'b1;
    tick();
    chk("mrel_setn", 32'(ifa.CHAIN_SETN), 32'd1);
    chk("mrel_busy", 32'(ifa.BUSY), 32'd0);
    tick();
    chk("mrel_idle", 32'(ifa.BUSY), 32'd0);

    // Busy START on DUT B: START held high for the whole run, PAT scrambled
    ifb.PAT = 8'hA5; ifb.EXP = 8'h5A;
    ifb.START = 1'b1;
    tick();
    cyc = 1; se_hi = 0; done_cnt = 0;
    forever begin
      ifb.PAT = 8'(cyc * 37 + 1);
      if (ifb.SE) se_hi++;
      if (ifb.DONE) done_cnt++;
      if (ifb.DONE || cyc >= 100) break;
      tick();
      cyc++;
    end
    chk("busy_done_cyc", 32'(cyc), 32'd21);
    chk("busy_se_hi", 32'(se_hi), 32'd16);
    tick();                          // START was high at the DONE edge
    ifb.START = 1'b0;
    chk("busy_after_done", 32'(ifb.BUSY), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (ifb.DONE) done_cnt++;
      tick();
    end
    chk("busy_one_run", 32'(done_cnt), 32'd1);
    chk("busy_still_idle", 32'(ifb.BUSY), 32'd0);
    chk("busy_resp", 32'(ifb.RESP), 32'h5A);
    chk("busy_fail", 32'(ifb.FAIL), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
